// File: rtl/sumcheck_round_verifier_pkg.sv
// Shared types and modular-arithmetic helpers for the sum-check round verifier.
package sumcheck_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_CHAL,
        ST_INTERP,
        ST_FINAL,
        ST_DONE
    } state_t;

    // Single conditional subtract; inputs are known to be below 2*m.
    function automatic logic [63:0] mod_red(input logic [63:0] x, input logic [63:0] m);
        return (x >= m) ? x - m : x;
    endfunction

    // Sum of two reduced values, then one conditional subtract.
    function automatic logic [63:0] mod_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] m);
        logic [63:0] s;
        s = a + b;
        return (s >= m) ? s - m : s;
    endfunction

    // Square-and-multiply exponentiation, used only at elaboration time.
    function automatic longint unsigned mod_pow(input longint unsigned base,
                                                input longint unsigned e,
                                                input longint unsigned m);
        longint unsigned r;
        longint unsigned b;
        r = 1;
        b = base % m;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r;
    endfunction

    // Fermat inverse; the modulus is prime.
    function automatic longint unsigned mod_inv(input longint unsigned a, input longint unsigned m);
        return mod_pow(a, m - 2, m);
    endfunction

    // Inverse of prod_{k!=i}(i-k) over the nodes 0..d, i.e. the Lagrange denominator.
    function automatic longint unsigned lagrange_weight(input int i, input int d,
                                                        input longint unsigned m);
        longint unsigned prod;
        longint unsigned term;
        int diff;
        prod = 1;
        for (int k = 0; k <= d; k++) begin
            if (k != i) begin
                diff = i - k;
                term = (diff < 0) ? m - longint'(-diff) : longint'(diff);
                prod = (prod * term) % m;
            end
        end
        return mod_inv(prod, m);
    endfunction

endpackage

// File: rtl/sumcheck_round_verifier_if.sv
// Prover / RNG / oracle handshakes plus the challenge commit strobe.
interface sumcheck_round_verifier_if #(
    parameter int FW = 31,
    parameter int RW = 3
);
    logic          eval_valid;
    logic          eval_ready;
    logic [FW-1:0] eval_data;
    logic          rand_valid;
    logic          rand_ready;
    logic [FW-1:0] rand_data;
    logic          oracle_valid;
    logic          oracle_ready;
    logic [FW-1:0] oracle_data;
    logic          chal_we;
    logic [RW-1:0] chal_idx;
    logic [FW-1:0] chal_data;

    modport master (
        output eval_valid, eval_data, rand_valid, rand_data, oracle_valid, oracle_data,
        input  eval_ready, rand_ready, oracle_ready, chal_we, chal_idx, chal_data
    );

    modport slave (
        input  eval_valid, eval_data, rand_valid, rand_data, oracle_valid, oracle_data,
        output eval_ready, rand_ready, oracle_ready, chal_we, chal_idx, chal_data
    );
endinterface

// File: rtl/sumcheck_round_verifier_mod_mul.sv
// Combinational field multiply: full double-width product reduced mod MODULUS.
module mod_mul #(
    parameter int              FIELD_WIDTH = 31,
    parameter longint unsigned MODULUS     = 2147483647
) (
    input  logic [FIELD_WIDTH-1:0] a,
    input  logic [FIELD_WIDTH-1:0] b,
    output logic [FIELD_WIDTH-1:0] y
);
    localparam int              PW    = 2 * FIELD_WIDTH;
    localparam logic [PW-1:0]   MOD_P = PW'(MODULUS);

    logic [PW-1:0] prod;

    // Product never overflows PW bits, so the remainder is exact.
    always_comb begin
        prod = PW'(a) * PW'(b);
        y    = FIELD_WIDTH'(prod % MOD_P);
    end
endmodule

// File: rtl/sumcheck_round_verifier.sv
// Multi-round sum-check verifier: consistency check, challenge draw and
// Lagrange evaluation of each round polynomial, then the final oracle compare.
module sumcheck_round_verifier
    import sumcheck_pkg::*;
#(
    parameter int              FIELD_WIDTH = 31,
    parameter longint unsigned MODULUS     = 2147483647,
    parameter int              NUM_VARS    = 6,
    parameter int              DEGREE      = 2,
    parameter int              RW          = $clog2(NUM_VARS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [FIELD_WIDTH-1:0] claim_in,
    sumcheck_round_verifier_if.slave bus,
    output logic                   busy,
    output logic                   done,
    output logic                   accept,
    output logic [RW-1:0]          reject_round
);
    localparam int                   NB    = DEGREE + 1;
    localparam int                   DW    = $clog2(NB);
    localparam logic [63:0]          MOD64 = 64'(MODULUS);
    localparam logic [FIELD_WIDTH:0] MOD_X = (FIELD_WIDTH + 1)'(MODULUS);

    state_t                 state_q, state_d;
    logic [FIELD_WIDTH-1:0] claim_q, claim_d;
    logic [FIELD_WIDTH-1:0] r_q, r_d;
    logic [FIELD_WIDTH-1:0] acc_q, acc_d;
    logic [FIELD_WIDTH-1:0] ev_q [NB];
    logic [FIELD_WIDTH-1:0] ev_d [NB];
    logic [RW-1:0]          j_q, j_d;
    logic [DW-1:0]          beat_q, beat_d;
    logic [DW-1:0]          term_q, term_d;
    logic                   accept_q, accept_d;
    logic [RW-1:0]          reject_round_q, reject_round_d;
    logic                   chal_we_q, chal_we_d;
    logic [RW-1:0]          chal_idx_q, chal_idx_d;
    logic [FIELD_WIDTH-1:0] chal_data_q, chal_data_d;

    logic [FIELD_WIDTH-1:0] claim_red, eval_red, rand_red, oracle_red;
    logic [FIELD_WIDTH-1:0] ev_sum, acc_sum, term_val;
    logic [FIELD_WIDTH-1:0] w_const [NB];
    logic [FIELD_WIDTH-1:0] diff [NB];
    logic [FIELD_WIDTH-1:0] fac [DEGREE];

    assign claim_red  = FIELD_WIDTH'(mod_red(64'(claim_in), MOD64));
    assign eval_red   = FIELD_WIDTH'(mod_red(64'(bus.eval_data), MOD64));
    assign rand_red   = FIELD_WIDTH'(mod_red(64'(bus.rand_data), MOD64));
    assign oracle_red = FIELD_WIDTH'(mod_red(64'(bus.oracle_data), MOD64));
    assign ev_sum     = FIELD_WIDTH'(mod_add(64'(ev_q[0]), 64'(ev_q[1]), MOD64));
    assign acc_sum    = FIELD_WIDTH'(mod_add(64'(acc_q), 64'(term_val), MOD64));

    // Lagrange weights W[i] and the differences (r - k) mod p for every node k.
    for (genvar g = 0; g < NB; g++) begin : g_node
        localparam longint unsigned WV = lagrange_weight(g, DEGREE, MODULUS);
        assign w_const[g] = FIELD_WIDTH'(WV);
        assign diff[g]    = (r_q >= FIELD_WIDTH'(g)) ? r_q - FIELD_WIDTH'(g)
                          : FIELD_WIDTH'({1'b0, r_q} + MOD_X - (FIELD_WIDTH + 1)'(g));
    end

    // Term i skips node i: slot m takes node m below i and node m+1 from i upward.
    for (genvar m = 0; m < DEGREE; m++) begin : g_fac
        assign fac[m] = (DW'(m) < term_q) ? diff[m] : diff[m + 1];
    end

    // Multiply chain ev[i] * W[i] * prod(r - k), one full term per cycle.
    for (genvar m = 0; m < NB; m++) begin : g_stage
        logic [FIELD_WIDTH-1:0] op_a, op_b, y_s;
        if (m == 0) begin : g_first
            assign op_a = ev_q[term_q];
            assign op_b = w_const[term_q];
        end else begin : g_next
            assign op_a = g_stage[m-1].y_s;
            assign op_b = fac[m-1];
        end
        mod_mul #(.FIELD_WIDTH(FIELD_WIDTH), .MODULUS(MODULUS)) u_mul (
            .a(op_a),
            .b(op_b),
            .y(y_s)
        );
    end
    assign term_val = g_stage[DEGREE].y_s;

    assign bus.eval_ready   = (state_q == ST_RECV);
    assign bus.rand_ready   = (state_q == ST_CHAL);
    assign bus.oracle_ready = (state_q == ST_FINAL);
    assign bus.chal_we      = chal_we_q;
    assign bus.chal_idx     = chal_idx_q;
    assign bus.chal_data    = chal_data_q;
    assign busy             = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done             = (state_q == ST_DONE);
    assign accept           = accept_q;
    assign reject_round     = reject_round_q;

    // Round sequencing: next state and next values of every register.
    always_comb begin
        state_d        = state_q;
        claim_d        = claim_q;
        r_d            = r_q;
        acc_d          = acc_q;
        ev_d           = ev_q;
        j_d            = j_q;
        beat_d         = beat_q;
        term_d         = term_q;
        accept_d       = accept_q;
        reject_round_d = reject_round_q;
        chal_we_d      = 1'b0;
        chal_idx_d     = chal_idx_q;
        chal_data_d    = chal_data_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    claim_d        = claim_red;
                    j_d            = '0;
                    beat_d         = '0;
                    term_d         = '0;
                    acc_d          = '0;
                    accept_d       = 1'b0;
                    reject_round_d = '0;
                    state_d        = ST_RECV;
                end
            end
            ST_RECV: begin
                if (bus.eval_valid) begin
                    ev_d[beat_q] = eval_red;
                    if (beat_q == DW'(DEGREE)) begin
                        beat_d  = '0;
                        state_d = ST_CHECK;
                    end else begin
                        beat_d = beat_q + DW'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (ev_sum != claim_q) begin
                    accept_d       = 1'b0;
                    reject_round_d = j_q;
                    state_d        = ST_DONE;
                end else begin
                    state_d = ST_CHAL;
                end
            end
            ST_CHAL: begin
                if (bus.rand_valid) begin
                    r_d         = rand_red;
                    chal_we_d   = 1'b1;
                    chal_idx_d  = j_q;
                    chal_data_d = rand_red;
                    acc_d       = '0;
                    term_d      = '0;
                    state_d     = ST_INTERP;
                end
            end
            ST_INTERP: begin
                acc_d = acc_sum;
                if (term_q == DW'(DEGREE)) begin
                    claim_d = acc_sum;
                    j_d     = j_q + RW'(1);
                    term_d  = '0;
                    state_d = (j_q + RW'(1) == RW'(NUM_VARS)) ? ST_FINAL : ST_RECV;
                end else begin
                    term_d = term_q + DW'(1);
                end
            end
            ST_FINAL: begin
                if (bus.oracle_valid) begin
                    accept_d       = (oracle_red == claim_q);
                    reject_round_d = (oracle_red == claim_q) ? '0 : RW'(NUM_VARS);
                    state_d        = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset clears everything including the challenge strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            claim_q        <= '0;
            r_q            <= '0;
            acc_q          <= '0;
            for (int i = 0; i < NB; i++) ev_q[i] <= '0;
            j_q            <= '0;
            beat_q         <= '0;
            term_q         <= '0;
            accept_q       <= 1'b0;
            reject_round_q <= '0;
            chal_we_q      <= 1'b0;
            chal_idx_q     <= '0;
            chal_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            claim_q        <= claim_d;
            r_q            <= r_d;
            acc_q          <= acc_d;
            ev_q           <= ev_d;
            j_q            <= j_d;
            beat_q         <= beat_d;
            term_q         <= term_d;
            accept_q       <= accept_d;
            reject_round_q <= reject_round_d;
            chal_we_q      <= chal_we_d;
            chal_idx_q     <= chal_idx_d;
            chal_data_q    <= chal_data_d;
        end
    end
endmodule

// File: tb/tb_sumcheck_round_verifier.sv
// Directed bench for the sum-check verifier over GF(97), two rounds, degree 2.
module tb_sumcheck_round_verifier;
    localparam int              FW  = 7;
    localparam longint unsigned MOD = 97;
    localparam int              NV  = 2;
    localparam int              DEG = 2;
    localparam int              RW  = 2;

    // Honest proof: g0 = 2x^2+2x+3, r0 = 5 -> 63; g1 = 2x^2+x+30, r1 = 4 -> 66.
    localparam logic [5:0][FW-1:0] HONEST_EVS  = {7'd40, 7'd33, 7'd30, 7'd15, 7'd7, 7'd3};
    localparam logic [1:0][FW-1:0] HONEST_RNDS = {7'd4, 7'd5};
    localparam logic [5:0][FW-1:0] BADSUM_EVS  = {7'd40, 7'd33, 7'd30, 7'd15, 7'd8, 7'd3};
    // Reduction proof: claim 107 = 10; r0 = 100 = 3 -> 27; g1 = 3x^2+24x (eval 97 = 0), r1 = 4 -> 47.
    localparam logic [5:0][FW-1:0] RED_EVS     = {7'd60, 7'd27, 7'd97, 7'd15, 7'd7, 7'd3};
    localparam logic [1:0][FW-1:0] RED_RNDS    = {7'd4, 7'd100};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [FW-1:0] claim_in;
    logic          busy;
    logic          done;
    logic          accept;
    logic [RW-1:0] reject_round;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int chal_cnt = 0;
    logic [RW-1:0] chal_idx_log [64];
    logic [FW-1:0] chal_data_log [64];

    sumcheck_round_verifier_if #(.FW(FW), .RW(RW)) bus ();

    sumcheck_round_verifier #(
        .FIELD_WIDTH(FW),
        .MODULUS(MOD),
        .NUM_VARS(NV),
        .DEGREE(DEG),
        .RW(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .claim_in(claim_in),
        .bus(bus),
        .busy(busy),
        .done(done),
        .accept(accept),
        .reject_round(reject_round)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every committed challenge, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.chal_we === 1'b1 && chal_cnt < 64) begin
            chal_idx_log[chal_cnt]  <= bus.chal_idx;
            chal_data_log[chal_cnt] <= bus.chal_data;
            chal_cnt                <= chal_cnt + 1;
        end
    end

    // Hard stop in case a scenario wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired");
        $fatal(1, "[TB] watchdog");
    end

    // Offer one beat on channel ch (0 eval, 1 rand, 2 oracle); called and returns at edge+1.
    task automatic drive_beat(input int ch, input logic [FW-1:0] val, input bit bp);
        int   gap;
        bit   ok;
        logic rdy;
        gap = bp ? int'($urandom_range(0, 3)) : 0;
        repeat (gap) begin @(posedge clk); #1; end
        ok = 1'b0;
        case (ch)
            0:       begin bus.eval_valid   = 1'b1; bus.eval_data   = val; end
            1:       begin bus.rand_valid   = 1'b1; bus.rand_data   = val; end
            default: begin bus.oracle_valid = 1'b1; bus.oracle_data = val; end
        endcase
        for (int t = 0; t < 100; t++) begin
            rdy = (ch == 0) ? bus.eval_ready : (ch == 1) ? bus.rand_ready : bus.oracle_ready;
            @(posedge clk); #1;
            if (rdy === 1'b1) begin ok = 1'b1; break; end
        end
        case (ch)
            0:       bus.eval_valid   = 1'b0;
            1:       bus.rand_valid   = 1'b0;
            default: bus.oracle_valid = 1'b0;
        endcase
        if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL handshake_ch%0d: ready got 0 required 1 within 100 cycles", ch);
        end
    endtask

    // mode 0 full proof, 1 stop after round-0 evals, 2 stop after round-0 challenge.
    task automatic run_flow(input logic [FW-1:0] claim, input logic [5:0][FW-1:0] evs,
                            input logic [1:0][FW-1:0] rnds, input logic [FW-1:0] orc,
                            input bit bp, input int mode, input bit glitch);
        start = 1'b1; claim_in = claim;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        for (int r = 0; r < NV; r++) begin
            if (glitch && r == 1) begin
                start = 1'b1; claim_in = 7'd50;
                @(posedge clk); #1;
                start = 1'b0;
            end
            for (int i = 0; i <= DEG; i++) drive_beat(0, evs[r*(DEG+1)+i], bp);
            if (mode == 1) return;
            drive_beat(1, rnds[r], bp);
            if (mode == 2) return;
        end
        drive_beat(2, orc, bp);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL wait_done: done got 0 required 1 within 200 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; claim_in = 7'd10;
        bus.eval_valid = 1'b1; bus.eval_data = 7'd3;
        bus.rand_valid = 1'b1; bus.rand_data = 7'd5;
        bus.oracle_valid = 1'b1; bus.oracle_data = 7'd66;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b required 0", done); end
        checks++; if (accept !== 1'b0) begin errors++; $display("[TB] FAIL reset_accept: got %b required 0", accept); end
        checks++; if (reject_round !== 2'd0) begin errors++; $display("[TB] FAIL reset_reject_round: got %0d required 0", reject_round); end
        checks++; if (bus.eval_ready !== 1'b0 || bus.rand_ready !== 1'b0 || bus.oracle_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ready: got %b%b%b required 000", bus.eval_ready, bus.rand_ready, bus.oracle_ready);
        end
        checks++; if (bus.chal_we !== 1'b0 || bus.chal_data !== 7'd0) begin
            errors++; $display("[TB] FAIL reset_chal: got we=%b data=%0d required 0/0", bus.chal_we, bus.chal_data);
        end
        rst = 1'b0; start = 1'b0;
        bus.eval_valid = 1'b0; bus.rand_valid = 1'b0; bus.oracle_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_honest();
        int base;
        base = chal_cnt;
        // A stray random word offered before CHAL must not be consumed.
        bus.rand_valid = 1'b1; bus.rand_data = 7'd99;
        run_flow(7'd10, HONEST_EVS, HONEST_RNDS, 7'd66, 1'b0, 0, 1'b0);
        wait_done();
        checks++; if (accept !== 1'b1) begin errors++; $display("[TB] FAIL honest_accept: got %b required 1", accept); end
        checks++; if (reject_round !== 2'd0) begin errors++; $display("[TB] FAIL honest_reject_round: got %0d required 0", reject_round); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL honest_busy: got %b required 0", busy); end
        checks++; if (cyc - start_cyc !== 17) begin errors++; $display("[TB] FAIL honest_latency: got %0d cycles required 17", cyc - start_cyc); end
        checks++; if (chal_cnt - base !== 2) begin errors++; $display("[TB] FAIL honest_chal_count: got %0d required 2", chal_cnt - base); end
        checks++; if (chal_idx_log[base] !== 2'd0 || chal_data_log[base] !== 7'd5) begin
            errors++; $display("[TB] FAIL honest_chal0: got (%0d,%0d) required (0,5)", chal_idx_log[base], chal_data_log[base]);
        end
        checks++; if (chal_idx_log[base+1] !== 2'd1 || chal_data_log[base+1] !== 7'd4) begin
            errors++; $display("[TB] FAIL honest_chal1: got (%0d,%0d) required (1,4)", chal_idx_log[base+1], chal_data_log[base+1]);
        end
    endtask

    task automatic test_bad_oracle();
        run_flow(7'd10, HONEST_EVS, HONEST_RNDS, 7'd65, 1'b0, 0, 1'b0);
        wait_done();
        checks++; if (accept !== 1'b0) begin errors++; $display("[TB] FAIL bad_oracle_accept: got %b required 0", accept); end
        checks++; if (reject_round !== 2'd2) begin errors++; $display("[TB] FAIL bad_oracle_reject_round: got %0d required 2", reject_round); end
    endtask

    task automatic test_bad_sum();
        int base;
        base = chal_cnt;
        run_flow(7'd10, BADSUM_EVS, HONEST_RNDS, 7'd66, 1'b0, 1, 1'b0);
        wait_done();
        checks++; if (accept !== 1'b0) begin errors++; $display("[TB] FAIL bad_sum_accept: got %b required 0", accept); end
        checks++; if (reject_round !== 2'd0) begin errors++; $display("[TB] FAIL bad_sum_reject_round: got %0d required 0", reject_round); end
        bus.eval_valid = 1'b1; bus.eval_data = 7'd1;
        for (int t = 0; t < 4; t++) begin
            checks++; if (bus.eval_ready !== 1'b0 || done !== 1'b1) begin
                errors++; $display("[TB] FAIL bad_sum_hold: got ready=%b done=%b required 0/1", bus.eval_ready, done);
            end
            @(posedge clk); #1;
        end
        bus.eval_valid = 1'b0;
        checks++; if (chal_cnt - base !== 0) begin errors++; $display("[TB] FAIL bad_sum_chal_count: got %0d required 0", chal_cnt - base); end
    endtask

    task automatic test_reduction();
        int base;
        base = chal_cnt;
        run_flow(7'd107, RED_EVS, RED_RNDS, 7'd47, 1'b0, 0, 1'b0);
        wait_done();
        checks++; if (chal_data_log[base] !== 7'd3) begin errors++; $display("[TB] FAIL reduction_chal_data: got %0d required 3", chal_data_log[base]); end
        checks++; if (accept !== 1'b1) begin errors++; $display("[TB] FAIL reduction_accept: got %b required 1", accept); end
    endtask

    task automatic test_back_pressure();
        int base;
        base = chal_cnt;
        run_flow(7'd10, HONEST_EVS, HONEST_RNDS, 7'd66, 1'b1, 0, 1'b0);
        wait_done();
        checks++; if (accept !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept: got %b required 1", accept); end
        checks++; if (chal_data_log[base] !== 7'd5 || chal_data_log[base+1] !== 7'd4) begin
            errors++; $display("[TB] FAIL bp_chal_data: got (%0d,%0d) required (5,4)", chal_data_log[base], chal_data_log[base+1]);
        end
    endtask

    task automatic test_reset_mid_interp();
        run_flow(7'd10, HONEST_EVS, HONEST_RNDS, 7'd66, 1'b0, 2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_state: got busy=%b done=%b required 0/0", busy, done); end
        checks++; if (bus.chal_we !== 1'b0 || bus.eval_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset_outputs: got we=%b ready=%b required 0/0", bus.chal_we, bus.eval_ready);
        end
        run_flow(7'd10, HONEST_EVS, HONEST_RNDS, 7'd66, 1'b0, 0, 1'b0);
        wait_done();
        checks++; if (accept !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_rerun_accept: got %b required 1", accept); end
    endtask

    task automatic test_back_to_back();
        run_flow(7'd10, HONEST_EVS, HONEST_RNDS, 7'd65, 1'b0, 0, 1'b0);
        wait_done();
        checks++; if (accept !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_accept: got %b required 0", accept); end
        // Restart from DONE; a start pulse mid-proof must be ignored.
        run_flow(7'd10, HONEST_EVS, HONEST_RNDS, 7'd66, 1'b0, 0, 1'b1);
        wait_done();
        checks++; if (accept !== 1'b1 || reject_round !== 2'd0) begin
            errors++; $display("[TB] FAIL b2b_second: got accept=%b round=%0d required 1/0", accept, reject_round);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; claim_in = '0;
        bus.eval_valid = 1'b0; bus.eval_data = '0;
        bus.rand_valid = 1'b0; bus.rand_data = '0;
        bus.oracle_valid = 1'b0; bus.oracle_data = '0;
        test_reset();
        test_honest();
        test_bad_oracle();
        test_bad_sum();
        test_reduction();
        test_back_pressure();
        test_reset_mid_interp();
        test_back_to_back();
        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
